// File: rtl/turf_generic_pkg.sv
// Shared types and constants for the TURF generic-interface responder.
package turf_generic_pkg;

    localparam int ADR_W = 28;
    localparam int DAT_W = 32;

    localparam logic [2:0] REG_ID      = 3'd0;
    localparam logic [2:0] REG_SCRATCH = 3'd1;
    localparam logic [2:0] REG_CTRL    = 3'd2;
    localparam logic [2:0] REG_TOCNT   = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXT_WAIT = 2'd1,
        ST_ACK      = 2'd2,
        ST_RECOVER  = 2'd3
    } state_t;

endpackage

// File: rtl/turf_generic_regs.sv
// Local register bank: ID, scratch, control and a wrapping timeout counter.
module turf_generic_regs
    import turf_generic_pkg::*;
#(
    parameter logic [DAT_W-1:0] ID_VALUE = 32'h54555246
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_stb,
    input  logic [2:0]       i_idx,
    input  logic [DAT_W-1:0] i_wr_dat,
    input  logic             i_to_inc,
    output logic [DAT_W-1:0] o_rd_dat,
    output logic [DAT_W-1:0] o_ctrl
);

    logic [DAT_W-1:0] r_scratch;
    logic [DAT_W-1:0] r_ctrl;
    logic [DAT_W-1:0] r_tocnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scratch <= '0;
            r_ctrl    <= '0;
            r_tocnt   <= '0;
        end else begin
            if (i_wr_stb) begin
                case (i_idx)
                    REG_SCRATCH: r_scratch <= i_wr_dat;
                    REG_CTRL:    r_ctrl    <= i_wr_dat;
                    default:     ;
                endcase
            end
            if (i_to_inc) begin
                r_tocnt <= r_tocnt + 1'b1;
            end
        end
    end

    always_comb begin
        o_rd_dat = '0;
        case (i_idx)
            REG_ID:      o_rd_dat = ID_VALUE;
            REG_SCRATCH: o_rd_dat = r_scratch;
            REG_CTRL:    o_rd_dat = r_ctrl;
            REG_TOCNT:   o_rd_dat = r_tocnt;
            default:     o_rd_dat = '0;
        endcase
    end

    assign o_ctrl = r_ctrl;

endmodule

// File: rtl/turf_generic_resp.sv
// Generic-interface responder: local register window plus timed downstream forwarding.
//   state       | meaning
//   ST_IDLE     | waiting for s_en_i; local hits go straight to ACK
//   ST_EXT_WAIT | downstream request pending, timeout counter running
//   ST_ACK      | s_ack_o high for this single cycle
//   ST_RECOVER  | one dead cycle ignoring late en and stale downstream acks
module turf_generic_resp
    import turf_generic_pkg::*;
#(
    parameter logic [DAT_W-1:0] ID_VALUE       = 32'h54555246,
    parameter int               LOCAL_AW       = 16,
    parameter int               TIMEOUT_CYCLES = 255,
    parameter logic [DAT_W-1:0] ERR_DATA       = 32'hDEADDEAD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_en_i,
    input  logic             s_wr_i,
    input  logic [ADR_W-1:0] s_adr_i,
    input  logic [DAT_W-1:0] s_dat_i,
    output logic             s_ack_o,
    output logic [DAT_W-1:0] s_dat_o,
    output logic             ext_en_o,
    output logic             ext_wr_o,
    output logic [ADR_W-1:0] ext_adr_o,
    output logic [DAT_W-1:0] ext_dat_o,
    input  logic             ext_ack_i,
    input  logic [DAT_W-1:0] ext_dat_i,
    output logic [DAT_W-1:0] ctrl_o
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [15:0]      r_tmo;
    logic             r_s_ack;
    logic [DAT_W-1:0] r_s_dat;
    logic             r_ext_en;
    logic             r_ext_wr;
    logic [ADR_W-1:0] r_ext_adr;
    logic [DAT_W-1:0] r_ext_dat;

    logic             w_local;
    logic             w_wr_stb;
    logic             w_to_hit;
    logic [DAT_W-1:0] w_rd_dat;

    assign w_local  = ((s_adr_i >> LOCAL_AW) == '0);
    assign w_wr_stb = (r_state == ST_IDLE) && s_en_i && w_local && s_wr_i;
    // A downstream ack in the final cycle wins over the timeout.
    assign w_to_hit = (r_state == ST_EXT_WAIT) && !ext_ack_i && (r_tmo == TO_LAST);

    turf_generic_regs #(
        .ID_VALUE (ID_VALUE)
    ) u_regs (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wr_stb (w_wr_stb),
        .i_idx    (s_adr_i[2:0]),
        .i_wr_dat (s_dat_i),
        .i_to_inc (w_to_hit),
        .o_rd_dat (w_rd_dat),
        .o_ctrl   (ctrl_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_tmo     <= '0;
            r_s_ack   <= 1'b0;
            r_s_dat   <= '0;
            r_ext_en  <= 1'b0;
            r_ext_wr  <= 1'b0;
            r_ext_adr <= '0;
            r_ext_dat <= '0;
        end else begin
            r_s_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (s_en_i) begin
                        if (w_local) begin
                            if (!s_wr_i) r_s_dat <= w_rd_dat;
                            r_s_ack <= 1'b1;
                            r_state <= ST_ACK;
                        end else begin
                            r_ext_en  <= 1'b1;
                            r_ext_wr  <= s_wr_i;
                            r_ext_adr <= s_adr_i;
                            r_ext_dat <= s_dat_i;
                            r_tmo     <= '0;
                            r_state   <= ST_EXT_WAIT;
                        end
                    end
                end
                ST_EXT_WAIT: begin
                    if (ext_ack_i) begin
                        r_ext_en <= 1'b0;
                        if (!r_ext_wr) r_s_dat <= ext_dat_i;
                        r_s_ack <= 1'b1;
                        r_state <= ST_ACK;
                    end else if (r_tmo == TO_LAST) begin
                        r_ext_en <= 1'b0;
                        if (!r_ext_wr) r_s_dat <= ERR_DATA;
                        r_s_ack <= 1'b1;
                        r_state <= ST_ACK;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_ACK:     r_state <= ST_RECOVER;
                ST_RECOVER: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_ack_o   = r_s_ack;
    assign s_dat_o   = r_s_dat;
    assign ext_en_o  = r_ext_en;
    assign ext_wr_o  = r_ext_wr;
    assign ext_adr_o = r_ext_adr;
    assign ext_dat_o = r_ext_dat;

endmodule

// File: tb/tb_turf_generic_resp.sv
// Directed bench for turf_generic_resp: local bank, external forwarding, timeout and reset.
module tb_turf_generic_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_en_i, s_wr_i;
    logic [27:0] s_adr_i;
    logic [31:0] s_dat_i;
    logic        s_ack_o;
    logic [31:0] s_dat_o;
    logic        ext_en_o, ext_wr_o;
    logic [27:0] ext_adr_o;
    logic [31:0] ext_dat_o;
    logic        ext_ack_i;
    logic [31:0] ext_dat_i;
    logic [31:0] ctrl_o;

    int n_checks = 0;
    int n_errors = 0;
    int cnt;

    always #5 clk = ~clk;

    turf_generic_resp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_en_i    (s_en_i),
        .s_wr_i    (s_wr_i),
        .s_adr_i   (s_adr_i),
        .s_dat_i   (s_dat_i),
        .s_ack_o   (s_ack_o),
        .s_dat_o   (s_dat_o),
        .ext_en_o  (ext_en_o),
        .ext_wr_o  (ext_wr_o),
        .ext_adr_o (ext_adr_o),
        .ext_dat_o (ext_dat_o),
        .ext_ack_i (ext_ack_i),
        .ext_dat_i (ext_dat_i),
        .ctrl_o    (ctrl_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Local access: en sampled at the next edge, ack seen right after, en dropped, idle 2 edges later.
    task automatic local_txn(input logic wr, input logic [27:0] adr, input logic [31:0] dat,
                             input string tag, input logic [31:0] exp_dat);
        s_en_i  = 1'b1;
        s_wr_i  = wr;
        s_adr_i = adr;
        s_dat_i = dat;
        tick();
        chk({tag, "_ack"}, {31'd0, s_ack_o}, 32'd1);
        chk({tag, "_dat"}, s_dat_o, exp_dat);
        s_en_i = 1'b0;
        tick();
        chk({tag, "_ack_low"}, {31'd0, s_ack_o}, 32'd0);
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        s_en_i    = 1'b0;
        s_wr_i    = 1'b0;
        s_adr_i   = '0;
        s_dat_i   = '0;
        ext_ack_i = 1'b0;
        ext_dat_i = '0;
        #1;
        chk("rst_ack", {31'd0, s_ack_o}, 32'd0);
        chk("rst_ext_en", {31'd0, ext_en_o}, 32'd0);
        chk("rst_sdat", s_dat_o, 32'd0);
        chk("rst_ctrl", ctrl_o, 32'd0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        local_txn(1'b0, 28'h0000000, 32'h0, "rd_id", 32'h54555246);
        local_txn(1'b1, 28'h0000001, 32'hA5A5_0001, "wr_scr", 32'h54555246);
        local_txn(1'b0, 28'h0000001, 32'h0, "rd_scr", 32'hA5A5_0001);
        local_txn(1'b0, 28'h0000009, 32'h0, "rd_alias", 32'hA5A5_0001);
        local_txn(1'b1, 28'h0000000, 32'hFFFF_FFFF, "wr_id", 32'hA5A5_0001);
        local_txn(1'b0, 28'h0000000, 32'h0, "rd_id2", 32'h54555246);
        local_txn(1'b1, 28'h0000005, 32'h1111_2222, "wr_rsv", 32'h54555246);
        local_txn(1'b0, 28'h0000005, 32'h0, "rd_rsv", 32'h0);

        s_en_i = 1'b1; s_wr_i = 1'b1; s_adr_i = 28'h0000002; s_dat_i = 32'h7;
        tick();
        chk("ctrl_ack", {31'd0, s_ack_o}, 32'd1);
        chk("ctrl_val", ctrl_o, 32'h7);
        s_en_i = 1'b0;
        tick();
        tick();
        local_txn(1'b0, 28'h000FFF2, 32'h0, "rd_ctrl", 32'h7);

        // External read answered after 5 cycles.
        s_en_i = 1'b1; s_wr_i = 1'b0; s_adr_i = 28'h0010000;
        tick();
        chk("ext_en_rise", {31'd0, ext_en_o}, 32'd1);
        chk("ext_adr", {4'd0, ext_adr_o}, 32'h0010000);
        chk("ext_wr", {31'd0, ext_wr_o}, 32'd0);
        cnt = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ext_en_o && !s_ack_o) cnt++;
        end
        chk("ext_en_hold", cnt, 32'd5);
        ext_ack_i = 1'b1; ext_dat_i = 32'h1234_5678;
        tick();
        chk("ext_en_fall", {31'd0, ext_en_o}, 32'd0);
        chk("ext_rd_ack", {31'd0, s_ack_o}, 32'd1);
        chk("ext_rd_dat", s_dat_o, 32'h1234_5678);
        ext_ack_i = 1'b0; s_en_i = 1'b0;
        tick();
        chk("ext_rd_ack_low", {31'd0, s_ack_o}, 32'd0);
        tick();

        // External write acked immediately; read data must stay put.
        s_en_i = 1'b1; s_wr_i = 1'b1; s_adr_i = 28'h0123456; s_dat_i = 32'hCAFE_BABE;
        tick();
        chk("extw_wr", {31'd0, ext_wr_o}, 32'd1);
        chk("extw_dat", ext_dat_o, 32'hCAFE_BABE);
        ext_ack_i = 1'b1; ext_dat_i = 32'hFFFF_FFFF;
        tick();
        chk("extw_ack", {31'd0, s_ack_o}, 32'd1);
        chk("extw_sdat", s_dat_o, 32'h1234_5678);
        ext_ack_i = 1'b0; s_en_i = 1'b0;
        tick();
        tick();

        // Timeout with no downstream ack, then a stale late ack.
        s_en_i = 1'b1; s_wr_i = 1'b0; s_adr_i = 28'h0200000;
        tick();
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (!ext_en_o) break;
            cnt++;
            tick();
        end
        chk("to_en_cycles", cnt, 32'd255);
        chk("to_ack", {31'd0, s_ack_o}, 32'd1);
        chk("to_dat", s_dat_o, 32'hDEAD_DEAD);
        s_en_i = 1'b0; ext_ack_i = 1'b1; ext_dat_i = 32'h1111_1111;
        tick();
        tick();
        tick();
        chk("late_ack_ign", {31'd0, s_ack_o}, 32'd0);
        chk("late_ack_dat", s_dat_o, 32'hDEAD_DEAD);
        chk("late_ack_en", {31'd0, ext_en_o}, 32'd0);
        ext_ack_i = 1'b0;
        tick();
        local_txn(1'b0, 28'h0000003, 32'h0, "rd_tocnt", 32'h1);

        // Ack arrives in the very cycle the timeout would fire.
        s_en_i = 1'b1; s_wr_i = 1'b0; s_adr_i = 28'h0300000;
        tick();
        for (int i = 0; i < 254; i++) tick();
        chk("race_en_still", {31'd0, ext_en_o}, 32'd1);
        ext_ack_i = 1'b1; ext_dat_i = 32'h0BAD_F00D;
        tick();
        chk("race_ack", {31'd0, s_ack_o}, 32'd1);
        chk("race_dat", s_dat_o, 32'h0BAD_F00D);
        ext_ack_i = 1'b0; s_en_i = 1'b0;
        tick();
        tick();
        local_txn(1'b0, 28'h0000003, 32'h0, "race_tocnt", 32'h1);

        // Initiator holds en two extra edges after ack: exactly one ack.
        s_en_i = 1'b1; s_wr_i = 1'b0; s_adr_i = 28'h0000001;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (s_ack_o) cnt++;
        end
        s_en_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (s_ack_o) cnt++;
        end
        chk("hold_en_acks", cnt, 32'd1);

        // Asynchronous reset during EXT_WAIT.
        s_en_i = 1'b1; s_wr_i = 1'b0; s_adr_i = 28'h0400000;
        tick();
        tick();
        chk("pre_rst_en", {31'd0, ext_en_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ext_en", {31'd0, ext_en_o}, 32'd0);
        chk("arst_ack", {31'd0, s_ack_o}, 32'd0);
        chk("arst_sdat", s_dat_o, 32'd0);
        chk("arst_ctrl", ctrl_o, 32'd0);
        s_en_i = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        local_txn(1'b0, 28'h0000003, 32'h0, "post_tocnt", 32'h0);
        local_txn(1'b0, 28'h0000001, 32'h0, "post_scr", 32'h0);
        local_txn(1'b1, 28'h0000001, 32'h5A5A_1234, "post_wr", 32'h0);
        local_txn(1'b0, 28'h0000001, 32'h0, "post_rd", 32'h5A5A_1234);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
